alu_ctrl_fsm: RTL and testbench
===============================

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

Interface
REQ-001 Parameter ARITH_LAT, default 2: execute cycles for the arithmetic unit (legal range 1..4).
REQ-002 Parameter OTHER_LAT, default 1: execute cycles for the logic, compare and shift units (legal range 1..4).
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 cmd_valid  input  1  command present; cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  4  opcode: [3:2] unit select, [1:0] function within the unit.
REQ-007 cmd_a, cmd_b  input  16 each  operands.
REQ-008 unit_sel  output  2  drives the downstream 2-to-4 unit decoder.
REQ-009 unit_func  output  2  function code to the selected unit.
REQ-010 unit_en  output  1  selected unit executing.
REQ-011 op_a, op_b  output  16 each  registered operands to the units.
REQ-012 unit_result  input  16  result from the selected unit; unit_flag  input  1  carry/compare flag.
REQ-013 res_valid  output  1; res_ready  input  1; res_data  output  16; res_flag  output  1  result channel.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, EXEC, DONE, and a fourth state reserved only for encoding; the reserved state SHALL return to IDLE on the next edge.
REQ-016 cmd_ready SHALL be 1 only in IDLE.
REQ-017 A handshake (cmd_valid & cmd_ready) at edge N SHALL latch cmd_op, cmd_a and cmd_b, load the latency counter with LAT-1, and enter EXEC.
- LAT = ARITH_LAT when cmd_op[3:2] = 2'b00.
- LAT = OTHER_LAT for all other unit selects.
REQ-018 In EXEC:
- unit_en = 1.
- unit_sel = latched op[3:2]; unit_func = latched op[1:0].
- op_a and op_b SHALL hold the latched operands.
- The counter SHALL decrement once per cycle.
REQ-019 In EXEC with counter = 0, the next edge SHALL capture unit_result into res_data and unit_flag into res_flag, and enter DONE.
REQ-020 res_valid SHALL be 1 only in DONE and SHALL first assert at cycle N+LAT+1.
REQ-021 In DONE, res_data and res_flag SHALL be stable until the handshake; res_valid & res_ready SHALL return the FSM to IDLE on that edge.
REQ-022 unit_en SHALL be 0 outside EXEC. unit_sel, unit_func, op_a and op_b SHALL hold their last values outside EXEC and SHALL NOT toggle.
REQ-023 All 16 opcodes are legal; no error path exists.
REQ-024 cmd_valid outside IDLE SHALL be ignored, with no state change.
REQ-025 res_ready outside DONE SHALL be ignored.
REQ-026 Maximum throughput is one command per LAT+2 cycles when res_ready is held at 1.

Reset
REQ-027 RST = 0 at a rising edge SHALL force IDLE and clear every register to 0, including mid-EXEC and mid-DONE. Output values after reset:
- cmd_ready = 1.
- unit_en = 0, res_valid = 0, busy = 0.
- unit_sel = 0, unit_func = 0, op_a = 0, op_b = 0.
- res_data = 0, res_flag = 0.
REQ-028 An in-flight command interrupted by reset SHALL be discarded and SHALL produce no res_valid.
REQ-029 cmd_valid asserted during reset SHALL NOT be accepted.

Structure
REQ-030 Shared package alu_pkg SHALL hold:
- the state encoding;
- the unit-select codes ARITH = 2'b00, LOGIC = 2'b01, CMP = 2'b10, SHIFT = 2'b11;
- the ALU data width constant 16.
REQ-031 One sub-module is natural: alu_lat_counter, a 2-bit down-counter with load, decrement and zero flag.
REQ-032 The existing decoder_2x4 is instantiated by the parent, not inside this block.

Verification
REQ-033 Logic op: cmd_op = 4'b0100, A = 16'h00F0, B = 16'h0F00, unit_result = 16'h0FF0, res_ready = 1, accepted at edge N -> unit_en high exactly one cycle, unit_sel = 01, res_valid at N+2, res_data = 16'h0FF0.
REQ-034 Arith op: cmd_op = 4'b0000, A = 16'hFFFF, B = 16'h0001, unit_result = 16'h0000, unit_flag = 1 -> unit_en high two cycles, res_valid at N+3, res_flag = 1.
REQ-035 Back-pressure: res_ready = 0 for 5 cycles in DONE -> res_valid and res_data stable, cmd_ready = 0, a second cmd_valid ignored; FSM returns to IDLE on the edge after res_ready rises.
REQ-036 Reset mid-EXEC: RST = 0 during arith EXEC cycle 1 -> next cycle IDLE with all outputs at reset values, and no res_valid ever issued for that command.
REQ-037 Sweep all 16 opcodes back-to-back with res_ready = 1 -> unit_sel/unit_func equal cmd_op, the decoder's one-hot output matches unit_sel, and per-command latency is ARITH_LAT+2 for unit 00 and OTHER_LAT+2 otherwise.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU control block.
//   ALU_W        data width of operands and results
//   ARITH..SHIFT unit-select codes carried in cmd_op[3:2]
//   state_e      controller state encoding (ST_RSVD only fills the 2-bit code space)
//   lat_load     counter preload (LAT-1) for a given unit select
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10,
    ST_RSVD = 2'b11
  } state_e;

  // Counter preload: the counter expires after LAT execute cycles.
  function automatic logic [1:0] lat_load(input logic [1:0] usel,
                                          input int arith_lat,
                                          input int other_lat);
    int lat;
    lat = (usel == ARITH) ? arith_lat : other_lat;
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// alu_lat_counter: 2-bit down-counter timing the execute phase.
//   CLK       clock, rising edge
//   RST       synchronous active-low reset
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one
//   zero      count is zero
module alu_lat_counter (
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (dec) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: sequences one command at a time through an external ALU unit.
//   CLK, RST               clock / synchronous active-low reset
//   cmd_valid/ready        command channel; cmd_op[3:2] unit, [1:0] function
//   cmd_a, cmd_b           operands, latched on accept
//   unit_sel/func/en       control to the external unit decoder and units
//   op_a, op_b             latched operands to the units
//   unit_result, unit_flag result from the selected unit
//   res_valid/ready        result channel carrying res_data / res_flag
//   busy                   high whenever not IDLE
// Flow: IDLE --accept--> EXEC (LAT cycles) --capture--> DONE --res handshake--> IDLE
module alu_ctrl_fsm
  import alu_pkg::*;
#(
  parameter int ARITH_LAT = 2,
  parameter int OTHER_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  output logic [1:0]       unit_sel,
  output logic [1:0]       unit_func,
  output logic             unit_en,
  output logic [ALU_W-1:0] op_a,
  output logic [ALU_W-1:0] op_b,
  input  logic [ALU_W-1:0] unit_result,
  input  logic             unit_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ALU_W-1:0] res_data,
  output logic             res_flag,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [ALU_W-1:0] a_q, a_d, b_q, b_d;
  logic [ALU_W-1:0] res_data_q, res_data_d;
  logic             res_flag_q, res_flag_d;
  logic             cnt_load, cnt_dec, cnt_zero;

  alu_lat_counter u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (lat_load(cmd_op[3:2], ARITH_LAT, OTHER_LAT)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_flag_d = res_flag_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          a_d      = cmd_a;
          b_d      = cmd_b;
          cnt_load = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Counter at zero marks the last execute cycle: unit output is final.
        if (cnt_zero) begin
          res_data_d = unit_result;
          res_flag_d = unit_flag;
          state_d    = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_flag_q <= res_flag_d;
    end
  end

  // Unit controls come straight from the command register, so they only
  // change on accept and hold otherwise.
  assign cmd_ready = (state_q == ST_IDLE);
  assign unit_en   = (state_q == ST_EXEC);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign unit_sel  = op_q[3:2];
  assign unit_func = op_q[1:0];
  assign op_a      = a_q;
  assign op_b      = b_q;
  assign res_data  = res_data_q;
  assign res_flag  = res_flag_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed stimulus with a scoreboard queue; a negedge
// monitor compares unit controls, latency and results against the queue.
module tb_alu_ctrl_fsm;
  import alu_pkg::*;

  localparam int AL = 2;
  localparam int OL = 1;

  logic        CLK, RST, cmd_valid, cmd_ready, unit_en, unit_flag;
  logic        res_valid, res_ready, res_flag, busy;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b, op_a, op_b, unit_result, res_data;
  logic [1:0]  unit_sel, unit_func;

  alu_ctrl_fsm #(.ARITH_LAT(AL), .OTHER_LAT(OL)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .unit_sel(unit_sel),
    .unit_func(unit_func), .unit_en(unit_en), .op_a(op_a), .op_b(op_b),
    .unit_result(unit_result), .unit_flag(unit_flag), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_flag(res_flag), .busy(busy)
  );

  initial begin CLK = 1'b0; forever #5 CLK = ~CLK; end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, data;
    logic        flag;
    int          acc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return (op[3:2] == ARITH) ? AL : OL;
  endfunction

  // ---------------- monitor ----------------
  logic [1:0]  p_sel, p_func;
  logic [15:0] p_a, p_b, hd;
  logic        hf;
  bit          rst_prev = 1'b0, seen = 1'b0;
  int          en_cnt = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      en_cnt = 0;
      seen   = 1'b0;
    end else begin
      if (rst_prev && !unit_en)
        check("hold_outside_exec", {unit_sel, unit_func, op_a, op_b}, {p_sel, p_func, p_a, p_b});
      if (unit_en) begin
        en_cnt++;
        if (q.size() > 0) begin
          check("unit_sel",  unit_sel,  q[0].op[3:2]);
          check("unit_func", unit_func, q[0].op[1:0]);
          check("op_a", op_a, q[0].a);
          check("op_b", op_b, q[0].b);
          check("decoder_onehot", 4'b0001 << unit_sel, 4'b0001 << q[0].op[3:2]);
          check("exec_busy", {busy, cmd_ready}, 2'b10);
        end
      end
      if (res_valid) begin
        if (q.size() == 0) begin
          check("spurious_res_valid", res_valid, 1'b0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", cyc - q[0].acc, lat_of(q[0].op));
            check("unit_en_cycles", en_cnt, lat_of(q[0].op));
            hd = res_data;
            hf = res_flag;
          end else begin
            check("done_stable", {res_data, res_flag}, {hd, hf});
          end
          check("done_cmd_ready", cmd_ready, 1'b0);
          if (res_ready) begin
            check("res_data", res_data, q[0].data);
            check("res_flag", res_flag, q[0].flag);
            void'(q.pop_front());
            seen   = 1'b0;
            en_cnt = 0;
          end
        end
      end
    end
    p_sel = unit_sel; p_func = unit_func; p_a = op_a; p_b = op_b;
    rst_prev = RST;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic f, input bit push, output int acc);
    int n;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    acc = -100;
    if (!cmd_ready) begin
      check("issue_ready_timeout", cmd_ready, 1'b1);
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; unit_result = r; unit_flag = f;
    cmd_valid = 1'b1;
    acc = cyc + 1;  // handshake lands on the next rising edge
    if (push) begin
      e.op = op; e.a = a; e.b = b; e.data = r; e.flag = f; e.acc = acc;
      q.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin tick(); n++; end
    check("drain", q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, {cmd_ready, unit_en, res_valid, busy}, 4'b1000);
    check({tag, "_unit"}, {unit_sel, unit_func, op_a, op_b}, 36'h0);
    check({tag, "_res"}, {res_data, res_flag}, 17'h0);
  endtask

  // Sweep vectors: A = 00F3, B = 0011, results as each unit would return them.
  logic [15:0] sw_res [16] = '{16'h0104, 16'h00E2, 16'h00F4, 16'h00F2,
                               16'h0011, 16'h00F3, 16'h00E2, 16'hFF0C,
                               16'h0000, 16'h0000, 16'h0001, 16'h0001,
                               16'h01E6, 16'h0079, 16'h0079, 16'h01E6};
  logic        sw_flg [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int acc, prev_acc, n;
    logic [3:0] prev_op;
    RST = 1'b0; cmd_valid = 1'b1; cmd_op = 4'b0101; cmd_a = 16'h1111; cmd_b = 16'h2222;
    unit_result = 16'h0; unit_flag = 1'b0; res_ready = 1'b1;
    // cmd_valid held during reset must not be accepted
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check_reset_vals("reset");
    cmd_valid = 1'b0; RST = 1'b1;
    tick();
    check("idle_after_reset", {cmd_ready, busy}, 2'b10);

    // logic op, LAT = 1
    issue(4'b0100, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b1, acc);
    wait_drain();
    // arith op, LAT = 2, carry out
    issue(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, acc);
    wait_drain();

    // back-pressure in DONE
    res_ready = 1'b0;
    issue(4'b1010, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, acc);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check("bp_res_valid", res_valid, 1'b1);
    unit_result = 16'hBAD0; unit_flag = 1'b0;  // must not leak into res_data
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", cmd_ready, 1'b0);
      cmd_op = 4'b0111;
      cmd_valid = (i == 1);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_still_valid", res_valid, 1'b1);
    res_ready = 1'b1;
    tick();
    check("bp_back_idle", {cmd_ready, busy, res_valid}, 3'b100);
    check("bp_popped", q.size(), 0);

    // reset during arith EXEC cycle 1: command discarded
    issue(4'b0001, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b0, acc);
    check("mid_exec_en", unit_en, 1'b1);
    RST = 1'b0;
    tick();
    check_reset_vals("mid_exec_reset");
    RST = 1'b1;
    repeat (4) tick();
    check("discarded_no_valid", res_valid, 1'b0);

    // all 16 opcodes back-to-back
    prev_acc = 0; prev_op = 4'h0;
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 16'h00F3, 16'h0011, sw_res[i], sw_flg[i], 1'b1, acc);
      if (i > 0) check("throughput", acc - prev_acc, lat_of(prev_op) + 2);
      prev_acc = acc; prev_op = 4'(i);
    end
    wait_drain();
    repeat (3) tick();
    check("final_idle", {cmd_ready, busy, res_valid, unit_en}, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
